// File: rtl/spi_slave_byte_if.sv
// Byte-oriented SPI slave bus: the serial pins plus the parallel tx/rx handshake.
// The slave modport is the block itself; the master modport is whoever drives it.
interface spi_slave_byte_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  cs;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  done;
  logic                  busy;
  logic                  frame_err;
  logic                  tx_underrun;

  modport slave (
    input  cs, sclk, mosi, tx_data, tx_load,
    output miso, tx_ready, rx_data, done, busy, frame_err, tx_underrun
  );

  modport master (
    output cs, sclk, mosi, tx_data, tx_load,
    input  miso, tx_ready, rx_data, done, busy, frame_err, tx_underrun
  );
endinterface

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI slave, oversampled in the system clock domain: synchronizes cs/sclk/mosi,
// shifts whole bytes in and out, and supports back-to-back bytes under one cs assertion.
module spi_slave_byte #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  spi_slave_byte_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sclkPrev;
  logic                   r_armed;

  logic                  w_cs;
  logic                  w_sclk;
  logic                  w_mosi;
  logic                  w_sclkRise;
  logic                  w_sclkFall;

  logic [DATA_WIDTH-1:0] r_txBuf;
  logic                  r_txFull;
  logic [DATA_WIDTH-1:0] r_txShift;
  logic                  r_holdFirst;
  logic [DATA_WIDTH-1:0] r_rxShift;
  logic [DATA_WIDTH-1:0] r_rxData;
  logic [CNT_W-1:0]      r_bitCnt;
  logic                  r_done;
  logic                  r_frameErr;
  logic                  r_underrun;

  logic w_frameStart;
  logic w_byteDone;
  logic w_abort;
  logic w_riseSample;
  logic w_fallShift;
  logic w_consume;

  // r_armed stays low after reset until cs is seen high, so a frame cut by reset is never resumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csSync   <= '0;
      r_sclkSync <= '0;
      r_mosiSync <= '0;
      r_sclkPrev <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], bus.cs};
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], bus.sclk};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], bus.mosi};
      r_sclkPrev <= w_sclk;
      if (w_cs) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_cs       = r_csSync[SYNC_STAGES-1];
  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_sclkFall = ~w_sclk & r_sclkPrev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_frameStart = 1'b0;
    w_byteDone   = 1'b0;
    w_abort      = 1'b0;
    w_riseSample = 1'b0;
    w_fallShift  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_cs && r_armed) begin
          w_nextState  = SHIFT;
          w_frameStart = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs) begin
          w_nextState = IDLE;
          w_abort     = (r_bitCnt != '0);
        end else begin
          w_riseSample = w_sclkRise;
          w_fallShift  = w_sclkFall;
          if (w_sclkRise && (r_bitCnt == LAST)) begin
            w_byteDone   = 1'b1;
            w_frameStart = 1'b1;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_consume = w_frameStart & r_txFull;

  // A byte reloaded on its final rise must skip the fall that follows, or its MSB is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txShift   <= '0;
      r_holdFirst <= 1'b0;
      r_rxShift   <= '0;
      r_rxData    <= '0;
      r_bitCnt    <= '0;
      r_done      <= 1'b0;
      r_frameErr  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_done     <= w_byteDone;
      r_frameErr <= w_abort;
      r_underrun <= w_frameStart & ~r_txFull;

      if (w_frameStart) begin
        r_txShift   <= r_txFull ? r_txBuf : '0;
        r_holdFirst <= w_byteDone;
      end else if (w_fallShift) begin
        if (r_holdFirst) begin
          r_holdFirst <= 1'b0;
        end else begin
          r_txShift <= {r_txShift[DATA_WIDTH-2:0], 1'b0};
        end
      end

      if (w_riseSample) begin
        r_rxShift <= {r_rxShift[DATA_WIDTH-2:0], w_mosi};
        r_bitCnt  <= w_byteDone ? '0 : r_bitCnt + 1'b1;
      end else if (w_frameStart) begin
        r_bitCnt <= '0;
      end

      if (w_byteDone) begin
        r_rxData <= {r_rxShift[DATA_WIDTH-2:0], w_mosi};
      end
    end
  end

  // A load coinciding with consumption refills the buffer immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_txBuf  <= '0;
      r_txFull <= 1'b0;
    end else begin
      if (bus.tx_load && (!r_txFull || w_consume)) begin
        r_txBuf  <= bus.tx_data;
        r_txFull <= 1'b1;
      end else if (w_consume) begin
        r_txFull <= 1'b0;
      end
    end
  end

  assign bus.miso        = (r_state == SHIFT) & r_txShift[DATA_WIDTH-1];
  assign bus.busy        = (r_state == SHIFT);
  assign bus.tx_ready    = ~r_txFull;
  assign bus.rx_data     = r_rxData;
  assign bus.done        = r_done;
  assign bus.frame_err   = r_frameErr;
  assign bus.tx_underrun = r_underrun;

endmodule

// File: doc/spi_slave_byte.md
SPI_SLAVE_BYTE -- requirements
Module: spi_slave_byte

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per SPI byte frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sclk/cs/mosi (min 2).
REQ-003 SHALL have one clock and asynchronous active-high reset, ports clk and reset, all state on posedge clk / posedge reset.
REQ-004 clk  input  1  system clock; all logic in this domain.
REQ-005 reset  input  1  async active-high reset.
REQ-006 cs  input  1  SPI chip select, active low, from master.
REQ-007 sclk  input  1  SPI serial clock, idle low (mode 0).
REQ-008 mosi  input  1  serial data from master, MSB first.
REQ-009 miso  output  1  serial data to master, MSB first.
REQ-010 tx_data  input  DATA_WIDTH  byte to return on the next frame.
REQ-011 tx_load  input  1  one-cycle strobe capturing tx_data into the tx buffer.
REQ-012 tx_ready  output  1  tx buffer empty; tx_load accepted only when high.
REQ-013 rx_data  output  DATA_WIDTH  last complete byte received.
REQ-014 done  output  1  one-cycle pulse: rx_data holds a new byte.
REQ-015 busy  output  1  high while a frame is in progress.
REQ-016 frame_err  output  1  one-cycle pulse: cs deasserted mid-frame.
REQ-017 tx_underrun  output  1  one-cycle pulse: frame started with empty tx buffer.

Function
REQ-018 cs, sclk, mosi SHALL pass through SYNC_STAGES flops; sclk edges detected on synchronized value (rise = prev 0, now 1).
REQ-019 Master timing supported: sclk high and low phases each >= 4 clk cycles; cs setup to first sclk rise >= 4 clk cycles.
REQ-020 FSM states IDLE, SHIFT; IDLE->SHIFT on synchronized cs low; SHIFT->IDLE on synchronized cs high.
REQ-021 Frame start (entering SHIFT, or byte complete with cs still low): tx shift reg loads tx buffer if full (buffer then empty, tx_ready high), else 0x00 and tx_underrun pulses; bit counter cleared.
REQ-022 miso SHALL present tx shift reg MSB from frame start; on each synchronized sclk fall, tx shift reg shifts left one bit.
REQ-023 On each synchronized sclk rise in SHIFT, mosi (synchronized) shifts into rx shift reg LSB; bit counter increments.
REQ-024 On the DATA_WIDTH-th rise: rx_data updated with the full byte and done pulses high on the following clk cycle; counter wraps to 0; next byte reloads per REQ-021 (back-to-back frames without cs toggle).
REQ-025 cs high with bit counter != 0: partial byte discarded, rx_data unchanged, no done, frame_err pulses one cycle, return IDLE.
REQ-026 cs high with bit counter == 0: return IDLE silently.
REQ-027 miso SHALL drive 0 in IDLE; no tristate inside this block.
REQ-028 busy = 1 exactly while in SHIFT.
REQ-029 tx_load while tx_ready low SHALL be ignored; buffer contents unchanged.
REQ-030 tx_load in same cycle as buffer consumption at frame start: old contents consumed, new tx_data captured, tx_ready stays low.
REQ-031 sclk edges while cs high SHALL be ignored.

Reset
REQ-032 reset high SHALL immediately force: state IDLE, miso 0, tx_ready 1, rx_data 0, done 0, busy 0, frame_err 0, tx_underrun 0, buffers, counters, synchronizers cleared.
REQ-033 reset mid-frame SHALL abort without done or frame_err; after release the block waits for a fresh cs falling edge (cs must be seen high first).

Verification
REQ-034 tx_load 0x3C, master sends 0xA5 -> done once, rx_data 0xA5, master receives 0x3C, tx_ready high after frame start.
REQ-035 Buffer 0x69, then 0xC4 loaded during byte 1; master sends 0x00,0x11 with cs held low -> two done pulses, rx_data 0x00 then 0x11, miso bytes 0x69, 0xC4.
REQ-036 No tx_load, master sends 0x5A -> tx_underrun one pulse at frame start, miso byte 0x00, rx_data 0x5A.
REQ-037 cs raised after 3 sclk rises -> frame_err one pulse, no done, rx_data unchanged, busy 0.
REQ-038 reset asserted after 5 bits of 0xFF -> all outputs at reset values; following full frame 0x81 -> rx_data 0x81, single done.
REQ-039 tx_load 0x11 then tx_load 0x22 with tx_ready low -> master receives 0x11; 0x22 never transmitted.
